// File: rtl/min_tree_pkg.sv
// Shared constants and elaboration-time helpers for the min/max reduction tree.
// Used by min2_node and min_tree_pipe.
package min_tree_pkg;

  typedef enum logic {
    MODE_MIN = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  // Number of compare levels needed to reduce n elements down to one.
  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  function automatic int half_up(input int n);
    return (n + 1) / 2;
  endfunction

  // Element count entering level lvl; level 0 holds the raw input vector.
  function automatic int width_at(input int n, input int lvl);
    int w;
    w = n;
    for (int i = 0; i < lvl; i++) w = half_up(w);
    return w;
  endfunction

endpackage

// File: rtl/min_tree_pipe_min2_node.sv
// Combinational two-input min/max select. On equal values the lower index wins,
// whichever mode is selected.
module min2_node
  import min_tree_pkg::*;
#(
  parameter int W  = 7,
  parameter int IW = 5
) (
  input  logic signed [W-1:0]  a_val,
  input  logic        [IW-1:0] a_idx,
  input  logic signed [W-1:0]  b_val,
  input  logic        [IW-1:0] b_idx,
  input  mode_e                mode,
  output logic signed [W-1:0]  y_val,
  output logic        [IW-1:0] y_idx
);

  logic b_better;
  logic b_tie_win;
  logic sel_b;

  always_comb begin
    b_better  = (mode == MODE_MAX) ? (b_val > a_val) : (b_val < a_val);
    // With index tracking disabled both indices are 0, so a (the lower pair slot) wins ties.
    b_tie_win = (b_val == a_val) && (b_idx < a_idx);
    sel_b     = b_better || b_tie_win;
    y_val     = sel_b ? b_val : a_val;
    y_idx     = sel_b ? b_idx : a_idx;
  end

endmodule

// File: rtl/min_tree_pipe.sv
// Pipelined signed min/max reduction tree: one compare level plus register stage per level.
// Define MIN_TREE_ARGMIN_EN to carry element indices through the tree and drive out_idx.
module min_tree_pipe
  import min_tree_pkg::*;
#(
  parameter int N  = 18,
  parameter int W  = 7,
  parameter int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*W-1:0]      in_vec,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode_max,
  output logic signed [W-1:0] out_val,
  output logic [IW-1:0]       out_idx,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int D = clog2_f(N);

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  genvar l, k;
  generate
    for (l = 0; l < D; l++) begin : g_lvl
      localparam int NI = width_at(N, l);
      localparam int NO = width_at(N, l + 1);

      logic signed [W-1:0] a_val [NI];
      logic signed [W-1:0] c_val [NO];
      logic signed [W-1:0] q_val [NO];
      mode_e               a_mode;
      mode_e               q_mode;
      logic                a_vld;
      logic                q_vld;
`ifdef MIN_TREE_ARGMIN_EN
      logic [IW-1:0]       a_idx [NI];
      logic [IW-1:0]       c_idx [NO];
      logic [IW-1:0]       q_idx [NO];
`endif

      if (l == 0) begin : g_src
        for (k = 0; k < NI; k++) begin : g_e
          assign a_val[k] = in_vec[k*W +: W];
`ifdef MIN_TREE_ARGMIN_EN
          assign a_idx[k] = IW'(k);
`endif
        end
        assign a_mode = mode_e'(mode_max);
        assign a_vld  = in_valid;
      end else begin : g_src
        assign a_val  = g_lvl[l-1].q_val;
`ifdef MIN_TREE_ARGMIN_EN
        assign a_idx  = g_lvl[l-1].q_idx;
`endif
        assign a_mode = g_lvl[l-1].q_mode;
        assign a_vld  = g_lvl[l-1].q_vld;
      end

      for (k = 0; k < NO; k++) begin : g_node
        if (2*k + 1 < NI) begin : g_cmp
`ifdef MIN_TREE_ARGMIN_EN
          min2_node #(.W(W), .IW(IW)) u_node (
            .a_val (a_val[2*k]),
            .a_idx (a_idx[2*k]),
            .b_val (a_val[2*k+1]),
            .b_idx (a_idx[2*k+1]),
            .mode  (a_mode),
            .y_val (c_val[k]),
            .y_idx (c_idx[k])
          );
`else
          logic [IW-1:0] idx_unused;
          min2_node #(.W(W), .IW(IW)) u_node (
            .a_val (a_val[2*k]),
            .a_idx ('0),
            .b_val (a_val[2*k+1]),
            .b_idx ('0),
            .mode  (a_mode),
            .y_val (c_val[k]),
            .y_idx (idx_unused)
          );
`endif
        end else begin : g_pass
          // Odd leftover skips the compare but still takes this level's register.
          assign c_val[k] = a_val[2*k];
`ifdef MIN_TREE_ARGMIN_EN
          assign c_idx[k] = a_idx[2*k];
`endif
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_vld  <= 1'b0;
          q_mode <= MODE_MIN;
          for (int i = 0; i < NO; i++) begin
            q_val[i] <= '0;
`ifdef MIN_TREE_ARGMIN_EN
            q_idx[i] <= '0;
`endif
          end
        end else if (adv) begin
          q_vld  <= a_vld;
          q_mode <= a_mode;
          q_val  <= c_val;
`ifdef MIN_TREE_ARGMIN_EN
          q_idx  <= c_idx;
`endif
        end
      end
    end
  endgenerate

  assign out_valid = g_lvl[D-1].q_vld;
  assign out_val   = g_lvl[D-1].q_val[0];
`ifdef MIN_TREE_ARGMIN_EN
  assign out_idx   = g_lvl[D-1].q_idx[0];
`else
  assign out_idx   = '0;
`endif

endmodule

// File: tb/tb_min_tree_pipe.sv
// Self-checking bench for min_tree_pipe (N=18, W=7) against a linear-scan reference model.
// Works with or without MIN_TREE_ARGMIN_EN; expected out_idx follows the build.
module tb_min_tree_pipe;

  localparam int N  = 18;
  localparam int W  = 7;
  localparam int IW = $clog2(N);
  localparam int D  = 5;
`ifdef MIN_TREE_ARGMIN_EN
  localparam bit ARGMIN = 1'b1;
`else
  localparam bit ARGMIN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N*W-1:0]      in_vec;
  logic                in_valid;
  logic                in_ready;
  logic                mode_max;
  logic signed [W-1:0] out_val;
  logic [IW-1:0]       out_idx;
  logic                out_valid;
  logic                out_ready;

  always #5 clk = ~clk;

  min_tree_pipe #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode_max  (mode_max),
    .out_val   (out_val),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic signed [W-1:0] v;
    logic [IW-1:0]       i;
    int                  c;
  } res_t;

  res_t got_q[$];
  res_t exp_q[$];
  res_t mon_r;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      mon_r.v = out_val;
      mon_r.i = out_idx;
      mon_r.c = cyc;
      got_q.push_back(mon_r);
    end
  end

  function automatic logic [IW-1:0] exp_idx(input int k);
    return ARGMIN ? IW'(k) : '0;
  endfunction

  // Linear scan; strict improvement keeps the earliest index on ties.
  function automatic res_t model(input logic [N*W-1:0] v, input logic m);
    res_t r;
    logic signed [W-1:0] e;
    logic signed [W-1:0] best;
    int bi;
    best = v[W-1:0];
    bi = 0;
    for (int k = 1; k < N; k++) begin
      e = v[k*W +: W];
      if ((m && e > best) || (!m && e < best)) begin
        best = e;
        bi = k;
      end
    end
    r.v = best;
    r.i = exp_idx(bi);
    r.c = 0;
    return r;
  endfunction

  function automatic logic signed [W-1:0] rand_elem();
    logic signed [W-1:0] e;
    case ($urandom_range(0, 5))
      0: e = {1'b1, {(W-1){1'b0}}};
      1: e = {1'b0, {(W-1){1'b1}}};
      2: e = W'(int'($urandom_range(0, 4)) - 2);
      default: e = W'($urandom);
    endcase
    return e;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = rand_elem();
    return v;
  endfunction

  task automatic send1(input logic [N*W-1:0] v, input logic m, output int t0);
    @(negedge clk);
    in_vec   = v;
    mode_max = m;
    in_valid = 1'b1;
    t0       = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit to);
    int b;
    b = 0;
    while (got_q.size() < n && b < budget) begin
      @(negedge clk);
      #2;
      b++;
    end
    to = (got_q.size() < n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_vec = '0; mode_max = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_val !== '0) begin n_fail++; $display("FAIL reset_out_val: got %0d want 0", out_val); end
    n_cmp++; if (out_idx !== '0) begin n_fail++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_min();
    logic [N*W-1:0] v; int t0; bit to;
    v = '0;
    v[5*W +: W] = W'(-64);
    got_q.delete();
    send1(v, 1'b0, t0);
    wait_results(1, 20, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL single_min_timeout: got 0 results want 1"); end
    else begin
      if (got_q[0].v !== W'(-64)) begin n_fail++; $display("FAIL single_min_val: got %0d want -64", got_q[0].v); end
      n_cmp++; if (got_q[0].i !== exp_idx(5)) begin n_fail++; $display("FAIL single_min_idx: got %0d want %0d", got_q[0].i, exp_idx(5)); end
      n_cmp++; if (got_q[0].c - t0 !== D) begin n_fail++; $display("FAIL single_min_latency: got %0d want %0d", got_q[0].c - t0, D); end
    end
  endtask

  task automatic test_ties();
    logic [N*W-1:0] v; int t0; bit to;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(20);
    v[3*W +: W] = W'(-7);
    v[11*W +: W] = W'(-7);
    got_q.delete();
    send1(v, 1'b0, t0);
    wait_results(1, 20, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL tie_min_timeout: got 0 results want 1"); end
    else begin
      if (got_q[0].v !== W'(-7)) begin n_fail++; $display("FAIL tie_min_val: got %0d want -7", got_q[0].v); end
      n_cmp++; if (got_q[0].i !== exp_idx(3)) begin n_fail++; $display("FAIL tie_min_idx: got %0d want %0d", got_q[0].i, exp_idx(3)); end
    end
    v[3*W +: W] = W'(63);
    v[11*W +: W] = W'(63);
    got_q.delete();
    send1(v, 1'b1, t0);
    wait_results(1, 20, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL tie_max_timeout: got 0 results want 1"); end
    else begin
      if (got_q[0].v !== W'(63)) begin n_fail++; $display("FAIL tie_max_val: got %0d want 63", got_q[0].v); end
      n_cmp++; if (got_q[0].i !== exp_idx(3)) begin n_fail++; $display("FAIL tie_max_idx: got %0d want %0d", got_q[0].i, exp_idx(3)); end
    end
  endtask

  task automatic test_odd_leftover();
    logic [N*W-1:0] v; int t0; bit to;
    v = '0;
    v[17*W +: W] = W'(-50);
    got_q.delete();
    send1(v, 1'b0, t0);
    wait_results(1, 20, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL odd_timeout: got 0 results want 1"); end
    else begin
      if (got_q[0].v !== W'(-50)) begin n_fail++; $display("FAIL odd_val: got %0d want -50", got_q[0].v); end
      n_cmp++; if (got_q[0].i !== exp_idx(17)) begin n_fail++; $display("FAIL odd_idx: got %0d want %0d", got_q[0].i, exp_idx(17)); end
      n_cmp++; if (got_q[0].c - t0 !== D) begin n_fail++; $display("FAIL odd_latency: got %0d want %0d", got_q[0].c - t0, D); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] v; logic m; bit to; int sent;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    sent = 0;
    while (sent < 10) begin
      @(negedge clk);
      v = rand_vec();
      m = 1'($urandom_range(0, 1));
      in_vec = v; mode_max = m; in_valid = 1'b1;
      #1;
      if (in_ready) begin exp_q.push_back(model(v, m)); sent++; end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_results(10, 30, to);
    repeat (3) @(negedge clk);
    n_cmp++; if (got_q.size() != 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", got_q.size()); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].v !== exp_q[i].v) begin n_fail++; $display("FAIL b2b_val[%0d]: got %0d want %0d", i, got_q[i].v, exp_q[i].v); end
      n_cmp++; if (got_q[i].i !== exp_q[i].i) begin n_fail++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", i, got_q[i].i, exp_q[i].i); end
      n_cmp++; if (got_q[i].c !== got_q[0].c + i) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, got_q[i].c, got_q[0].c + i); end
    end
  endtask

  task automatic test_stall();
    logic [N*W-1:0] v; logic m; bit to; int sent; int b;
    logic signed [W-1:0] held_v; logic [IW-1:0] held_i;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    sent = 0;
    while (sent < 3) begin
      @(negedge clk);
      v = rand_vec(); m = 1'($urandom_range(0, 1));
      in_vec = v; mode_max = m; in_valid = 1'b1;
      #1;
      if (in_ready) begin exp_q.push_back(model(v, m)); sent++; end
    end
    @(negedge clk);
    in_valid = 1'b0;
    b = 0;
    while (out_valid !== 1'b1 && b < 20) begin @(negedge clk); #2; b++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_wait_valid: got %0b want 1", out_valid); end
    held_v = out_val; held_i = out_idx;
    v = rand_vec(); m = 1'($urandom_range(0, 1));
    in_vec = v; mode_max = m; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", c, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d]: got %0b want 1", c, out_valid); end
      n_cmp++; if (out_val !== held_v) begin n_fail++; $display("FAIL stall_val_stable[%0d]: got %0d want %0d", c, out_val, held_v); end
      n_cmp++; if (out_idx !== held_i) begin n_fail++; $display("FAIL stall_idx_stable[%0d]: got %0d want %0d", c, out_idx, held_i); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    if (in_ready) exp_q.push_back(model(v, m));
    @(negedge clk);
    in_valid = 1'b0;
    wait_results(exp_q.size(), 30, to);
    repeat (4) @(negedge clk);
    n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].v !== exp_q[i].v) begin n_fail++; $display("FAIL stall_val[%0d]: got %0d want %0d", i, got_q[i].v, exp_q[i].v); end
      n_cmp++; if (got_q[i].i !== exp_q[i].i) begin n_fail++; $display("FAIL stall_idx[%0d]: got %0d want %0d", i, got_q[i].i, exp_q[i].i); end
    end
  endtask

  task automatic test_reset_flush();
    logic [N*W-1:0] v; logic m; bit to; int sent; int b; int t0; res_t r;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    sent = 0;
    while (sent < 3) begin
      @(negedge clk);
      v = rand_vec(); m = 1'($urandom_range(0, 1));
      in_vec = v; mode_max = m; in_valid = 1'b1;
      #1;
      if (in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    b = 0;
    while (out_valid !== 1'b1 && b < 20) begin @(negedge clk); #2; b++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_wait_valid: got %0b want 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_val !== '0) begin n_fail++; $display("FAIL flush_out_val: got %0d want 0", out_val); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_leak: got %0d results want 0", got_q.size()); end
    got_q.delete();
    v = rand_vec(); m = 1'($urandom_range(0, 1));
    r = model(v, m);
    send1(v, m, t0);
    wait_results(1, 20, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL flush_after_timeout: got 0 results want 1"); end
    else begin
      if (got_q[0].v !== r.v) begin n_fail++; $display("FAIL flush_after_val: got %0d want %0d", got_q[0].v, r.v); end
      n_cmp++; if (got_q[0].i !== r.i) begin n_fail++; $display("FAIL flush_after_idx: got %0d want %0d", got_q[0].i, r.i); end
      n_cmp++; if (got_q[0].c - t0 !== D) begin n_fail++; $display("FAIL flush_after_latency: got %0d want %0d", got_q[0].c - t0, D); end
    end
  endtask

  task automatic test_random_stream();
    logic [N*W-1:0] v; logic m; bit to; int sent; int budget;
    got_q.delete(); exp_q.delete();
    sent = 0; budget = 0;
    v = rand_vec(); m = 1'($urandom_range(0, 1));
    while (sent < 60 && budget < 1000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_vec = v; mode_max = m;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(v, m));
        sent++;
        v = rand_vec(); m = 1'($urandom_range(0, 1));
      end
      budget++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    wait_results(exp_q.size(), 40, to);
    repeat (3) @(negedge clk);
    n_cmp++; if (got_q.size() != 60) begin n_fail++; $display("FAIL rand_count: got %0d want 60", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i].v !== exp_q[i].v) begin n_fail++; $display("FAIL rand_val[%0d]: got %0d want %0d", i, got_q[i].v, exp_q[i].v); end
      n_cmp++; if (got_q[i].i !== exp_q[i].i) begin n_fail++; $display("FAIL rand_idx[%0d]: got %0d want %0d", i, got_q[i].i, exp_q[i].i); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_min();
    test_ties();
    test_odd_leftover();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/min_tree_pipe.md
MIN_TREE_PIPE -- requirements
Module: min_tree_pipe

Interface
REQ-001 The block SHALL have parameter N, default 18, meaning number of input elements (2..64).
REQ-002 The block SHALL have parameter W, default 7, meaning signed element width in bits (2..16).
REQ-003 The block SHALL have parameter IW, default $clog2(N), meaning index width.
REQ-004 The block SHALL have port clk, input, 1, meaning single clock; all flops rise on posedge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port in_vec, input, N*W, meaning element k at bits [k*W+W-1 : k*W], signed two's complement.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_vec is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts in_vec this cycle.
REQ-009 The block SHALL have port mode_max, input, 1, meaning 0 selects min and 1 selects max; sampled with in_vec.
REQ-010 The block SHALL have port out_val, output, W, meaning the selected extreme value, signed.
REQ-011 The block SHALL have port out_idx, output, IW, meaning the element index of out_val (ARGMIN build only).
REQ-012 The block SHALL have port out_valid, output, 1, meaning out_val/out_idx are valid.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the downstream block accepts the output.

Function
REQ-014 The block SHALL compute, per accepted vector, the signed min (mode_max=0) or max (mode_max=1) of all N elements.
REQ-015 The tree SHALL have D = $clog2(N) compare levels, each followed by a register stage; latency SHALL be exactly D cycles from the accept to out_valid when there is no stall (N=18: D=5).
REQ-016 At each level, elements SHALL be paired in ascending index order (2j, 2j+1); an odd leftover SHALL pass uncompared to the next level, delayed by the same register stage.
REQ-017 The tie rule SHALL be: on equal values the lower original index wins, in both modes.
REQ-018 Comparison SHALL be full-width signed; there SHALL be no saturation or truncation; -2^(W-1) and 2^(W-1)-1 SHALL be handled correctly.
REQ-019 mode_max SHALL travel with its vector through the pipeline, so that mixed-mode vectors in flight each resolve with their own mode.
REQ-020 An input SHALL be accepted when in_valid && in_ready; an output SHALL be transferred when out_valid && out_ready.
REQ-021 A stall SHALL be defined as stall = out_valid && !out_ready; in_ready SHALL equal !stall; during a stall all stage registers and valid bits SHALL hold.
REQ-022 Bubbles SHALL propagate: when in_valid=0 on an accept cycle, a 0 valid SHALL enter stage 1.
REQ-023 out_val/out_idx SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 The block SHALL sustain a throughput of 1 vector/cycle when out_ready=1.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously clear all stage valid bits, out_valid, out_val and out_idx to 0; in_ready SHALL then read 1.
REQ-026 A reset asserted mid-stream SHALL discard all in-flight vectors; the first vector accepted after deassertion SHALL emerge after D cycles.

Configuration
REQ-027 With MIN_TREE_ARGMIN_EN defined, index fields SHALL be carried through every stage and out_idx SHALL be driven.
REQ-028 Without MIN_TREE_ARGMIN_EN, index registers SHALL be omitted and out_idx SHALL be tied to 0; out_val and its timing SHALL be unchanged.

Structure
REQ-029 Package min_tree_pkg SHALL hold the level-count function (clog2), the per-level width function (ceil(n/2)), and the MODE_MIN/MODE_MAX constants.
REQ-030 Sub-module min2_node SHALL be a combinational two-input select with value, index and mode inputs and the REQ-017 tie rule; the top SHALL generate the tree and the registers from it.

Verification (N=18, W=7)
REQ-031 Scenario: in_vec all 0 except a5=-64, mode_max=0 -> after 5 cycles out_val=-64, out_idx=5.
REQ-032 Scenario: a3=a11=-7, all other elements 20, mode_max=0 -> out_val=-7, out_idx=3; with mode_max=1 and a3=a11=63 -> out_val=63, out_idx=3.
REQ-033 Scenario: odd leftover, a17=-50, all other elements 0 -> out_val=-50, out_idx=17, latency 5.
REQ-034 Scenario: 10 back-to-back random vectors with out_ready=1 -> 10 results on consecutive cycles, in order, matching the model; then out_ready held low 3 cycles -> in_ready=0 and out_val stable for those cycles, no loss or duplicate.
REQ-035 Scenario: rst_n pulsed low with 3 vectors in flight -> out_valid=0 immediately; none of the 3 vectors appears afterward.
REQ-036 Scenario: build without MIN_TREE_ARGMIN_EN -> out_idx=0 always; out_val identical to the ARGMIN build for the same stimulus.
